// File: rtl/zarb_seq_if.sv
// zarb_seq_if: start/busy/done handshake and operand/product bus
// for the zarb_seq sequential multiplier.
interface zarb_seq_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               signed_op;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] F;

  modport master (
    output start,
    output A,
    output B,
    output signed_op,
    input  busy,
    input  done,
    input  F
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    input  signed_op,
    output busy,
    output done,
    output F
  );
endinterface

// File: rtl/zarb_seq.sv
// zarb_seq: WIDTH-iteration shift-add multiplier, one adder.
// SIGNED_MUL_EN compiles in two's-complement mode (signed_op).
module zarb_seq #(
  parameter int WIDTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  zarb_seq_if.slave s
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + 1;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    mc_q, mc_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    f_q, f_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW-1:0]    pp;
  logic             last;
  logic             ext;

`ifdef SIGNED_MUL_EN
  logic sgn_q, sgn_d;
  assign ext = s.signed_op & s.A[WIDTH-1];
`else
  logic unused_signed_op;
  assign unused_signed_op = s.signed_op;
  assign ext = 1'b0;
`endif

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign pp   = mr_q[0] ? mc_q : '0;

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SIGNED_MUL_EN
    sgn_d   = sgn_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s.start) begin
          mc_d    = {{(WIDTH + 1){ext}}, s.A};
          mr_d    = s.B;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SIGNED_MUL_EN
          sgn_d   = s.signed_op;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
`ifdef SIGNED_MUL_EN
        // B[WIDTH-1] carries negative weight in two's complement
        if (last && sgn_q) begin
          acc_d = acc_q - pp;
        end else begin
          acc_d = acc_q + pp;
        end
`else
        acc_d = acc_q + pp;
`endif
        mc_d  = {mc_q[AW-2:0], 1'b0};
        mr_d  = mr_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        f_d     = acc_q[PW-1:0];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mc_q    <= '0;
      acc_q   <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_MUL_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIGNED_MUL_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign s.busy = busy_q;
  assign s.done = done_q;
  assign s.F    = f_q;
endmodule

// File: tb/tb_zarb_seq.sv
// tb_zarb_seq: randomized self-checking bench for zarb_seq,
// WIDTH=4 and WIDTH=8 instances against an arithmetic model.
module tb_zarb_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  zarb_seq_if #(.WIDTH(4)) b4 ();
  zarb_seq_if #(.WIDTH(8)) b8 ();

  zarb_seq #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .s   (b4)
  );

  zarb_seq #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .s   (b8)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [15:0] model(
    input int w, input logic [7:0] a, input logic [7:0] b,
    input logic sg);
    longint sa, sb, p, mask;
    logic honour;
    honour = sg;
`ifndef SIGNED_MUL_EN
    honour = 1'b0;
`endif
    sa = longint'(a);
    sb = longint'(b);
    if (honour) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    p    = sa * sb;
    mask = (longint'(1) << (2 * w)) - 1;
    return 16'(p & mask);
  endfunction

  task automatic issue4(
    input logic [3:0] a, input logic [3:0] b, input logic sg,
    input logic hold,
    output int lat, output int busy_n, output logic overlap,
    output logic [7:0] f);
    b4.A = a;
    b4.B = b;
    b4.signed_op = sg;
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    b4.start = hold;
    b4.A = 4'($urandom);
    b4.B = 4'($urandom);
    b4.signed_op = 1'($urandom);
    lat = -1;
    busy_n = 0;
    overlap = 1'b0;
    f = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (b4.busy) busy_n++;
      if (b4.busy && b4.done) overlap = 1'b1;
      if (b4.done) begin
        lat = k;
        f = b4.F;
        break;
      end
    end
  endtask

  task automatic issue8(
    input logic [7:0] a, input logic [7:0] b, input logic sg,
    output int lat, output int busy_n, output logic [15:0] f);
    b8.A = a;
    b8.B = b;
    b8.signed_op = sg;
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    b8.A = 8'($urandom);
    b8.B = 8'($urandom);
    lat = -1;
    busy_n = 0;
    f = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (b8.busy) busy_n++;
      if (b8.done) begin
        lat = k;
        f = b8.F;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    b4.start = 1'b1;
    b8.start = 1'b1;
    b4.A = 4'd3; b4.B = 4'd3; b4.signed_op = 1'b0;
    b8.A = 8'd3; b8.B = 8'd3; b8.signed_op = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({b4.F, b4.busy, b4.done} !== 10'd0) begin
      $display("FAIL reset4: F=%h busy=%b done=%b want 0/0/0",
               b4.F, b4.busy, b4.done);
    end else n_pass++;
    n_total++;
    if ({b8.F, b8.busy, b8.done} !== 18'd0) begin
      $display("FAIL reset8: F=%h busy=%b done=%b want 0/0/0",
               b8.F, b8.busy, b8.done);
    end else n_pass++;
    rst = 1'b0;
    b4.start = 1'b0;
    b8.start = 1'b0;
    busy_seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (b4.busy || b4.done || b8.busy || b8.done) busy_seen++;
    end
    n_total++;
    if (busy_seen !== 0) begin
      $display("FAIL reset_start_drop: active cycles=%0d want 0",
               busy_seen);
    end else n_pass++;
  endtask

  task automatic test_max4();
    int lat, bn;
    logic ov;
    logic [7:0] f;
    issue4(4'hF, 4'hF, 1'b0, 1'b0, lat, bn, ov, f);
    n_total++;
    if (lat !== 5) $display("FAIL max4_lat: got %0d want 5", lat);
    else n_pass++;
    n_total++;
    if (f !== 8'hE1) $display("FAIL max4_F: got %h want e1", f);
    else n_pass++;
    n_total++;
    if (bn !== 4 || ov !== 1'b0)
      $display("FAIL max4_busy: busy=%0d ov=%b want 4/0", bn, ov);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (b4.F !== 8'hE1 || b4.done !== 1'b0)
      $display("FAIL max4_hold: F=%h done=%b want e1/0",
               b4.F, b4.done);
    else n_pass++;
  endtask

  task automatic test_exhaustive();
    int lat, bn, bad, extra;
    logic ov;
    logic [7:0] f;
    logic [7:0] exp;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue4(4'(a), 4'(b), 1'b0, 1'b1, lat, bn, ov, f);
        exp = 8'(model(4, 8'(a), 8'(b), 1'b0));
        n_total++;
        if (lat !== 5 || f !== exp || bn !== 4 || ov) begin
          bad++;
          $display("FAIL exh %0d*%0d: F=%h lat=%0d busy=%0d want %h/5/4",
                   a, b, f, lat, bn, exp);
        end else n_pass++;
        if (bad > 10) break;
      end
      if (bad > 10) break;
    end
    b4.start = 1'b0;
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (b4.busy || b4.done) extra++;
    end
    n_total++;
    if (extra !== 0)
      $display("FAIL exh_idle: active cycles=%0d want 0", extra);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [3:0] ta [6] = '{4'h8, 4'h8, 4'h7, 4'h8, 4'h8, 4'h7};
    logic [3:0] tb [6] = '{4'h8, 4'h7, 4'hF, 4'h8, 4'h7, 4'hF};
    logic       ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef SIGNED_MUL_EN
    logic [7:0] te [6] = '{8'h40, 8'hC8, 8'hF9, 8'h40, 8'h38, 8'h69};
    logic [7:0] ff_exp = 8'h01;
`else
    logic [7:0] te [6] = '{8'h40, 8'h38, 8'h69, 8'h40, 8'h38, 8'h69};
    logic [7:0] ff_exp = 8'hE1;
`endif
    int lat, bn;
    logic ov;
    logic [7:0] f;
    logic [3:0] ra, rb;
    logic rs;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      issue4(ta[i], tb[i], ts[i], 1'b0, lat, bn, ov, f);
      n_total++;
      if (f !== te[i] || lat !== 5)
        $display("FAIL signed_tab%0d: F=%h lat=%0d want %h/5",
                 i, f, lat, te[i]);
      else n_pass++;
    end
    issue4(4'hF, 4'hF, 1'b1, 1'b0, lat, bn, ov, f);
    n_total++;
    if (f !== ff_exp)
      $display("FAIL signed_ff: F=%h want %h", f, ff_exp);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      exp = 8'(model(4, {4'h0, ra}, {4'h0, rb}, rs));
      issue4(ra, rb, rs, 1'b0, lat, bn, ov, f);
      n_total++;
      if (f !== exp || lat !== 5)
        $display("FAIL signed_rand %h*%h s=%b: F=%h lat=%0d want %h",
                 ra, rb, rs, f, lat, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, dn;
    logic ov;
    logic [7:0] f;
    issue4(4'd6, 4'd7, 1'b0, 1'b0, lat, bn, ov, f);
    n_total++;
    if (f !== 8'h2A) $display("FAIL rmid_pre: F=%h want 2a", f);
    else n_pass++;
    b4.A = 4'd9;
    b4.B = 4'd5;
    b4.signed_op = 1'b0;
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    b4.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if (b4.F !== 8'h00 || b4.busy !== 1'b0 || b4.done !== 1'b0)
      $display("FAIL rmid_abort: F=%h busy=%b done=%b want 0/0/0",
               b4.F, b4.busy, b4.done);
    else n_pass++;
    dn = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (b4.done || b4.busy) dn++;
    end
    n_total++;
    if (dn !== 0) $display("FAIL rmid_nodone: active=%0d want 0", dn);
    else n_pass++;
    issue4(4'd3, 4'd4, 1'b0, 1'b0, lat, bn, ov, f);
    n_total++;
    if (f !== 8'h0C || lat !== 5)
      $display("FAIL rmid_next: F=%h lat=%0d want 0c/5", f, lat);
    else n_pass++;
  endtask

  task automatic test_width8();
    int lat, bn;
    logic [15:0] f, exp;
    logic [7:0] ra, rb;
    logic rs;
    issue8(8'd255, 8'd255, 1'b0, lat, bn, f);
    n_total++;
    if (f !== 16'hFE01 || lat !== 9 || bn !== 8)
      $display("FAIL w8_max: F=%h lat=%0d busy=%0d want fe01/9/8",
               f, lat, bn);
    else n_pass++;
    issue8(8'd0, 8'd200, 1'b0, lat, bn, f);
    n_total++;
    if (f !== 16'h0000 || lat !== 9)
      $display("FAIL w8_zero: F=%h lat=%0d want 0000/9", f, lat);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      exp = model(8, ra, rb, rs);
      issue8(ra, rb, rs, lat, bn, f);
      n_total++;
      if (f !== exp || lat !== 9)
        $display("FAIL w8_rand %h*%h s=%b: F=%h lat=%0d want %h",
                 ra, rb, rs, f, lat, exp);
      else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    b4.start = 1'b0;
    b4.A = '0;
    b4.B = '0;
    b4.signed_op = 1'b0;
    b8.start = 1'b0;
    b8.A = '0;
    b8.B = '0;
    b8.signed_op = 1'b0;
    test_reset();
    test_max4();
    test_exhaustive();
    test_signed();
    test_reset_mid();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
